// File: rtl/truth_table_sweeper.sv
// Exhaustive sweep-and-check engine: walks every N_IN-bit input vector in order,
// compares the block's single-bit output with a golden truth table, and reports the result.
module truth_table_sweeper #(
   parameter int                   N_IN      = 4,
   parameter int                   HOLD      = 2,
   parameter logic [(2**N_IN)-1:0] EXPECTED  = '0,
   parameter logic [(2**N_IN)-1:0] SKIP_MASK = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dut_out,
   output logic [N_IN-1:0] vec,
   output logic            vec_valid,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail,
   output logic            fail_seen
);

   localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
   localparam logic [N_IN-1:0] LAST_VEC  = '1;
   localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

   state_t          state;
   logic [HW-1:0]   hold_cnt;
   logic            skip_now;
   logic            sample_now;
   logic            mismatch;
   logic            step;
   logic [N_IN-1:0] next_vec;
   logic [N_IN:0]   err_next;

   // A skipped vector lasts one cycle; an applied one is sampled on its last hold cycle.
   assign skip_now   = SKIP_MASK[vec];
   assign sample_now = !skip_now && (hold_cnt == HOLD_LAST);
   assign mismatch   = dut_out != EXPECTED[vec];
   assign step       = skip_now || sample_now;
   assign next_vec   = vec + N_IN'(1);
   assign err_next   = (sample_now && mismatch) ? err_count + ERR_ONE : err_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         vec        <= '0;
         vec_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
         fail_seen  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= APPLY;
                  hold_cnt   <= '0;
                  vec        <= '0;
                  vec_valid  <= !SKIP_MASK[0];
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  first_fail <= '0;
                  fail_seen  <= 1'b0;
               end
            end
            APPLY: begin
               if (step) begin
                  hold_cnt  <= '0;
                  err_count <= err_next;
                  if (sample_now && mismatch && !fail_seen) begin
                     first_fail <= vec;
                     fail_seen  <= 1'b1;
                  end
                  // The final compare is folded into pass through err_next.
                  if (vec == LAST_VEC) begin
                     state     <= DONE;
                     vec_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     pass      <= (err_next == '0);
                  end else begin
                     vec       <= next_vec;
                     vec_valid <= !SKIP_MASK[next_vec];
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three parameterisations driven by randomized fault
// injection and checked against a per-vector model of the sweep outcome.
module tb_truth_table_sweeper;

   localparam logic [15:0] EXP_MAIN = 16'hA5C3;
   localparam logic [15:0] SKIP_SK  = 16'h0809;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   int          sel;
   logic [15:0] inv;
   int          checkCount = 0;
   int          errorCount = 0;

   logic [3:0] vecM, ffM, vecS, ffS;
   logic [4:0] errM, errS;
   logic [1:0] vecA, ffA;
   logic [2:0] errA;
   logic       dutM, vvM, busyM, doneM, passM, fsM;
   logic       dutS, vvS, busyS, doneS, passS, fsS;
   logic       dutA, vvA, busyA, doneA, passA, fsA;

   logic [7:0] obsVec, obsFf, obsErr;
   logic       obsVv, obsBusy, obsDone, obsPass, obsFs;

   always #5 clk = ~clk;

   truth_table_sweeper #(.N_IN(4), .HOLD(2), .EXPECTED(EXP_MAIN), .SKIP_MASK(16'h0000)) uMain (
      .clk(clk), .rst(rst), .start(start && sel == 0), .dut_out(dutM), .vec(vecM),
      .vec_valid(vvM), .busy(busyM), .done(doneM), .pass(passM), .err_count(errM),
      .first_fail(ffM), .fail_seen(fsM));

   truth_table_sweeper #(.N_IN(4), .HOLD(2), .EXPECTED(EXP_MAIN), .SKIP_MASK(SKIP_SK)) uSkip (
      .clk(clk), .rst(rst), .start(start && sel == 1), .dut_out(dutS), .vec(vecS),
      .vec_valid(vvS), .busy(busyS), .done(doneS), .pass(passS), .err_count(errS),
      .first_fail(ffS), .fail_seen(fsS));

   truth_table_sweeper #(.N_IN(2), .HOLD(1), .EXPECTED(4'b1000), .SKIP_MASK(4'b0000)) uAnd (
      .clk(clk), .rst(rst), .start(start && sel == 2), .dut_out(dutA), .vec(vecA),
      .vec_valid(vvA), .busy(busyA), .done(doneA), .pass(passA), .err_count(errA),
      .first_fail(ffA), .fail_seen(fsA));

   // Blocks under test: the golden function, with inv selecting vectors to corrupt.
   always_comb begin
      dutM = EXP_MAIN[vecM] ^ inv[vecM];
      dutS = EXP_MAIN[vecS] ^ inv[vecS];
      dutA = (&vecA) ^ inv[vecA];
   end

   always_comb begin
      obsVec = '0; obsFf = '0; obsErr = '0;
      obsVv = 1'b0; obsBusy = 1'b0; obsDone = 1'b0; obsPass = 1'b0; obsFs = 1'b0;
      case (sel)
         0: begin
            obsVec = {4'b0, vecM}; obsFf = {4'b0, ffM}; obsErr = {3'b0, errM};
            obsVv = vvM; obsBusy = busyM; obsDone = doneM; obsPass = passM; obsFs = fsM;
         end
         1: begin
            obsVec = {4'b0, vecS}; obsFf = {4'b0, ffS}; obsErr = {3'b0, errS};
            obsVv = vvS; obsBusy = busyS; obsDone = doneS; obsPass = passS; obsFs = fsS;
         end
         default: begin
            obsVec = {6'b0, vecA}; obsFf = {6'b0, ffA}; obsErr = {5'b0, errA};
            obsVv = vvA; obsBusy = busyA; obsDone = doneA; obsPass = passA; obsFs = fsA;
         end
      endcase
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Runs one sweep on instance s; restartAt>0 pulses start mid-sweep, tail idles after done.
   task automatic applyStimulus(input int s, input logic [15:0] injected, input int restartAt,
                                input int tail);
      int nvec, hold, expLen, expErr, expFirst, expSeen, expValid;
      int cyc, applyCyc, doneAt, doneCnt, badValid, badStep, validCnt, prevVec;
      logic [15:0] skip;
      logic        prevBusy;
      nvec = (s == 2) ? 4 : 16;
      hold = (s == 2) ? 1 : 2;
      skip = (s == 1) ? SKIP_SK : 16'h0000;
      expLen = 0; expErr = 0; expFirst = 0; expSeen = 0; expValid = 0;
      for (int i = 0; i < nvec; i++) begin
         if (skip[i]) expLen += 1;
         else begin
            expLen   += hold;
            expValid += hold;
            if (injected[i]) begin
               expErr++;
               if (expSeen == 0) begin expFirst = i; expSeen = 1; end
            end
         end
      end

      @(negedge clk);
      sel = s; inv = injected; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("errCleared", obsErr, 0);
      checkOutput("failSeenCleared", obsFs, 0);
      checkOutput("passCleared", obsPass, 0);
      checkOutput("busyOn", obsBusy, 1);

      cyc = 0; applyCyc = 0; doneAt = 0; doneCnt = 0; badValid = 0; badStep = 0;
      validCnt = 0; prevVec = 0; prevBusy = 1'b0;
      for (int guard = 0; guard < 200; guard++) begin
         cyc++;
         start = (cyc == restartAt);
         if (obsBusy) applyCyc++;
         if (obsVv) validCnt++;
         if (obsDone) begin
            doneCnt++;
            if (doneAt == 0) doneAt = cyc;
         end
         if (obsVv && (!obsBusy || skip[obsVec])) badValid++;
         if (obsBusy && !skip[obsVec] && !obsVv) badValid++;
         if (obsBusy && prevBusy && int'(obsVec) != prevVec && int'(obsVec) != prevVec + 1)
            badStep++;
         prevVec  = int'(obsVec);
         prevBusy = obsBusy;
         if (doneAt != 0 && cyc >= doneAt + tail) break;
         @(negedge clk);
      end
      start = 1'b0;

      if (doneAt == 0) checkOutput("doneTimeout", 0, 1);
      checkOutput("applyCycles", applyCyc, expLen);
      checkOutput("doneCycle", doneAt, expLen + 1);
      checkOutput("doneCount", doneCnt, 1);
      checkOutput("validCycles", validCnt, expValid);
      checkOutput("validOnSkipOrIdle", badValid, 0);
      checkOutput("vecStep", badStep, 0);
      checkOutput("errCount", obsErr, expErr);
      checkOutput("failSeen", obsFs, expSeen);
      checkOutput("firstFail", obsFf, expFirst);
      checkOutput("pass", obsPass, (expErr == 0) ? 1 : 0);
      checkOutput("busyOff", obsBusy, 0);
   endtask

   initial begin
      logic [15:0] r;
      rst = 1'b1; start = 1'b0; sel = 0; inv = '0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checkOutput("rstVec", obsVec, 0);
         checkOutput("rstBusy", obsBusy, 0);
         checkOutput("rstDone", obsDone, 0);
         checkOutput("rstPass", obsPass, 0);
         checkOutput("rstErr", obsErr, 0);
         checkOutput("rstFailSeen", obsFs, 0);
      end
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] clean and faulty sweeps");
      applyStimulus(0, 16'h0000, 0, 3);
      applyStimulus(0, 16'h1020, 0, 3);

      $display("[TB] skip mask");
      applyStimulus(1, 16'h0809, 0, 3);
      applyStimulus(1, 16'h0821, 0, 3);

      $display("[TB] start ignored mid-sweep, then back-to-back");
      applyStimulus(0, 16'h0100, 10, 0);
      applyStimulus(0, 16'h0000, 0, 3);

      $display("[TB] reset mid-sweep");
      @(negedge clk);
      sel = 0; inv = 16'h0020; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      checkOutput("preResetErr", obsErr, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midRstVec", obsVec, 0);
      checkOutput("midRstValid", obsVv, 0);
      checkOutput("midRstBusy", obsBusy, 0);
      checkOutput("midRstErr", obsErr, 0);
      checkOutput("midRstFailSeen", obsFs, 0);
      checkOutput("midRstFirstFail", obsFf, 0);
      repeat (3) @(negedge clk);
      checkOutput("stayIdleBusy", obsBusy, 0);
      checkOutput("stayIdleVec", obsVec, 0);
      applyStimulus(0, 16'h0000, 0, 3);

      $display("[TB] AND gate");
      applyStimulus(2, 16'h0000, 0, 3);
      applyStimulus(2, 16'h0008, 0, 3);

      $display("[TB] randomized sweeps");
      for (int n = 0; n < 8; n++) begin
         r = 16'($urandom);
         if ($urandom_range(0, 3) == 0) r = '0;
         applyStimulus(int'($urandom_range(0, 2)), r, 0, int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
